// File: rtl/fifo_burst_reader.sv
// Read engine for fifo_sync: pulls a len-word burst via r_en and replays it as valid/ready/last.
// Optional RD_TIMEOUT_EN: abort a burst that stalls on an empty FIFO for TIMEOUT_CYCLES.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LEN_BITS       = 8,
  parameter int unsigned OUT_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  start_i,
  input  logic [LEN_BITS-1:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LEN_BITS-1:0]   xfer_cnt_o,
  output logic                  fifo_rd_en_o,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
  begin : g_bad_param
    $error("fifo_burst_reader: OUT_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                r_state;
  logic [LEN_BITS-1:0]   r_len;
  logic [LEN_BITS-1:0]   r_recv_cnt;
  logic                  r_inflight;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW:0]         r_occ;
  logic [DATA_WIDTH-1:0] r_buf_data [OUT_DEPTH];
  logic                  r_buf_last [OUT_DEPTH];

  logic                  w_start;
  logic                  w_capture;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_rd_en;
  logic                  w_timeout;
  logic [LEN_BITS:0]     w_recv_next;

  assign w_start     = (r_state == StIdle) && start_i && (len_i != '0);
  // The FIFO presents the word one cycle after r_en, and only if it is non-empty then.
  assign w_capture   = r_inflight && !fifo_empty_i;
  assign w_last      = (r_recv_cnt == r_len - LEN_BITS'(1));
  assign w_recv_next = {1'b0, r_recv_cnt} + (LEN_BITS + 1)'(w_capture);
  assign w_pop       = m_valid_o && m_ready_i;

  // Counting the in-flight read against both len and buffer space prevents over-read/overflow.
  assign w_rd_en = resetn_i && (r_state == StRun) && !fifo_empty_i && !w_timeout
                && (({1'b0, r_recv_cnt} + (LEN_BITS + 1)'(r_inflight)) < {1'b0, r_len})
                && ((r_occ + (PtrW + 1)'(r_inflight)) < (PtrW + 1)'(OUT_DEPTH));

`ifdef RD_TIMEOUT_EN
  localparam int unsigned TmrW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TmrW-1:0] r_timer;
  logic            r_err;

  assign w_timeout = (r_state == StRun) && (r_timer == TmrW'(TIMEOUT_CYCLES)) && !r_inflight;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state != StRun || w_capture) begin
        r_timer <= '0;
      end else if (fifo_empty_i && r_timer != TmrW'(TIMEOUT_CYCLES)) begin
        r_timer <= r_timer + TmrW'(1);
      end
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_recv_cnt <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_capture) begin
        r_recv_cnt <= r_recv_cnt + LEN_BITS'(1);
      end
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_len      <= len_i;
            r_recv_cnt <= '0;
            r_state    <= StRun;
          end
        end
        StRun: begin
          if (w_recv_next == {1'b0, r_len} || w_timeout) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (r_occ == '0) begin
            r_state <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_occ <= r_occ + (PtrW + 1)'(w_capture) - (PtrW + 1)'(w_pop);
    end
  end

  // Storage needs no reset: occupancy gates everything read out of it.
  always_ff @(posedge clk_i) begin
    if (w_capture) begin
      r_buf_data[r_wr_ptr] <= fifo_data_i;
      r_buf_last[r_wr_ptr] <= w_last;
    end
  end

  assign m_valid_o    = (r_occ != '0);
  assign m_data_o     = m_valid_o ? r_buf_data[r_rd_ptr] : '0;
  assign m_last_o     = m_valid_o && r_buf_last[r_rd_ptr];
  assign busy_o       = (r_state != StIdle);
  assign done_o       = (r_state == StDone);
  assign xfer_cnt_o   = r_recv_cnt;
  assign fifo_rd_en_o = w_rd_en;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: behavioural registered-read FIFO plus a stream
// scoreboard that expects exactly the words the FIFO popped, in order, with last on the len-th.
module tb_fifo_burst_reader;
  localparam int DW = 32;
  localparam int LB = 8;
  localparam int OD = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [LB-1:0] len = '0;
  logic          busy, done, err;
  logic [LB-1:0] xfer_cnt;
  logic          rd_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .LEN_BITS(LB), .OUT_DEPTH(OD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .resetn_i(resetn), .start_i(start), .len_i(len),
    .busy_o(busy), .done_o(done), .err_o(err), .xfer_cnt_o(xfer_cnt),
    .fifo_rd_en_o(rd_en), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: r_en registered; the head is shown and popped in the next cycle if non-empty.
  logic [DW-1:0] fmem [0:63];
  int            fhead = 0, ftail = 0;
  logic          ren_q = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] exp_q [$];
  int            tot_pops = 0, tot_rd = 0, cyc = 0;

  assign fifo_empty = (fhead == ftail);
  assign fifo_data  = (ren_q && fhead != ftail) ? fmem[fhead & 63] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) tot_rd++;
    if (ren_q && fhead != ftail) begin
      exp_q.push_back(fmem[fhead & 63]);
      tot_pops++;
      fhead <= fhead + 1;
    end
    if (wr_en) begin
      fmem[ftail & 63] <= wr_data;
      ftail <= ftail + 1;
    end
    if (flush) fhead <= ftail;
    ren_q <= rd_en;
  end

  // Stream-side expectations
  int            cur_len = 1, beat_idx = 0, last_cnt = 0, pops_base = 0;
  int            first_rd = -1, first_beat = -1, last_beat_cyc = -100, done_cyc = -1;
  int            done_cnt = 0, exp_xfer = 0, occ_m = 0;
  bit            exp_err = 1'b0, in_burst = 1'b0, tmo_mode = 1'b0;
  bit            prev_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] got [0:63];
  int            rdy_mode = 0;

  always @(negedge clk) begin
    if (!resetn) chk("rd_en_in_reset", {63'd0, rd_en}, 64'd0);
    if (prev_stall) begin
      chk("hold_valid", {63'd0, m_valid}, 64'd1);
      chk("hold_data", {32'd0, m_data}, {32'd0, prev_data});
      chk("hold_last", {63'd0, m_last}, {63'd0, prev_last});
    end
    if (m_valid) begin
      chk("beat_data", {32'd0, m_data},
          (exp_q.size() != 0) ? {32'd0, exp_q[0]} : 64'h1_0000_0000);
      chk("beat_last", {63'd0, m_last}, {63'd0, (beat_idx == cur_len - 1)});
      if (m_ready && resetn) begin
        if (beat_idx < 64) got[beat_idx] = m_data;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (first_beat < 0) first_beat = cyc;
        if (m_last) begin
          last_cnt++;
          last_beat_cyc = cyc;
        end
        beat_idx++;
      end
    end else begin
      chk("idle_data", {32'd0, m_data}, 64'd0);
      chk("idle_last", {63'd0, m_last}, 64'd0);
    end
    if (in_burst) begin
      occ_m = tot_pops - pops_base - beat_idx;
      checks++;
      if (occ_m > OD || tot_pops - pops_base > cur_len) begin
        errors++;
        $display("FAIL occupancy: held=%0d popped=%0d required held<=%0d popped<=%0d",
                 occ_m, tot_pops - pops_base, OD, cur_len);
      end
    end
    if (rd_en && first_rd < 0) first_rd = cyc;
    if (!tmo_mode)
      chk("done_timing", {63'd0, done}, {63'd0, (cyc == last_beat_cyc + 2)});
    chk("busy", {63'd0, busy}, {63'd0, in_burst});
    if (done) begin
      chk("done_xfer_cnt", {56'd0, xfer_cnt}, 64'(exp_xfer));
      chk("done_err", {63'd0, err}, {63'd0, exp_err});
      chk("done_delivered", 64'(beat_idx), 64'(exp_xfer));
      in_burst = 1'b0;
      done_cyc = cyc;
      done_cnt++;
    end
    prev_stall = m_valid && !m_ready && resetn;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    in_burst = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_burst(input int n, input int xfer, input bit e);
    beat_idx = 0; last_cnt = 0; first_rd = -1; first_beat = -1;
    cur_len = n; exp_xfer = xfer; exp_err = e; pops_base = tot_pops;
    start = 1'b1; len = LB'(n);
    @(posedge clk); #1;
    start = 1'b0;
    in_burst = 1'b1;
  endtask

  task automatic wait_done(input int bound);
    int  base = done_cnt;
    bit  ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_wait: no done_o within %0d cycles, required one pulse", bound);
      do_reset();
      do_flush();
    end
  endtask

  task automatic trickle(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      push($urandom);
    end
  endtask

  initial begin
    int s_cyc, rd0, n, pre;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_xfer", {56'd0, xfer_cnt}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Preloaded burst of 8 at full rate
    for (int i = 0; i < 8; i++) push(32'h10 + i);
    start_burst(8, 8, 1'b0);
    wait_done(100);
    for (int i = 0; i < 8; i++) chk("t1_data", {32'd0, got[i]}, 64'h10 + 64'(i));
    chk("t1_last_count", 64'(last_cnt), 64'd1);
    chk("t1_first_latency", 64'(first_beat - first_rd), 64'd2);
    chk("t1_back_to_back", 64'(last_beat_cyc - first_beat), 64'd7);

    // Partial read from a deeper FIFO
    for (int i = 0; i < 12; i++) push(32'h20 + i);
    rd0 = tot_rd;
    start_burst(5, 5, 1'b0);
    wait_done(100);
    chk("t2_rd_en_count", 64'(tot_rd - rd0), 64'd5);
    chk("t2_fifo_left", 64'(ftail - fhead), 64'd7);
    chk("t2_fifo_empty", {63'd0, fifo_empty}, 64'd0);
    chk("t2_last_word", {32'd0, got[4]}, 64'h24);
    do_flush();

    // Empty FIFO, slow writer
    start_burst(4, 4, 1'b0);
    fork
      for (int i = 0; i < 4; i++) begin
        repeat (2) begin @(posedge clk); #1; end
        push(32'hA1 + i);
      end
      wait_done(200);
    join
    for (int i = 0; i < 4; i++) chk("t3_data", {32'd0, got[i]}, 64'hA1 + 64'(i));
    chk("t3_last_count", 64'(last_cnt), 64'd1);

    // Toggling ready
    for (int i = 0; i < 6; i++) push(32'h30 + i);
    rdy_mode = 1;
    start_burst(6, 6, 1'b0);
    wait_done(200);
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) chk("t4_data", {32'd0, got[i]}, 64'h30 + 64'(i));
    chk("t4_last_count", 64'(last_cnt), 64'd1);

    // Reset mid-burst, then a clean short burst
    for (int i = 0; i < 8; i++) push(32'h40 + i);
    start_burst(8, 8, 1'b0);
    for (int i = 0; i < 50 && beat_idx < 3; i++) begin @(posedge clk); #1; end
    chk("t5_three_beats", 64'(beat_idx), 64'd3);
    do_reset();
    @(negedge clk);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_valid", {63'd0, m_valid}, 64'd0);
    chk("t5_xfer", {56'd0, xfer_cnt}, 64'd0);
    @(posedge clk); #1;
    do_flush();
    push(32'h50);
    push(32'h51);
    start_burst(2, 2, 1'b0);
    wait_done(100);
    chk("t5_new_0", {32'd0, got[0]}, 64'h50);
    chk("t5_new_1", {32'd0, got[1]}, 64'h51);

    // Randomized bursts: partial preload, trickling writer, random ready
    rdy_mode = 2;
    for (int k = 0; k < 12; k++) begin
      n   = $urandom_range(1, 12);
      pre = $urandom_range(0, n);
      for (int i = 0; i < pre; i++) push($urandom);
      start_burst(n, n, 1'b0);
      fork
        trickle(n - pre + $urandom_range(0, 2), 3);
        wait_done(600);
      join
      chk("rand_last_count", 64'(last_cnt), 64'd1);
      do_flush();
    end
    rdy_mode = 0;

`ifdef RD_TIMEOUT_EN
    // Short FIFO: burst aborts after the empty-stall limit
    tmo_mode = 1'b1;
    push(32'h60);
    push(32'h61);
    s_cyc = cyc;
    start_burst(4, 2, 1'b1);
    wait_done(200);
    chk("tmo_last_count", 64'(last_cnt), 64'd0);
    chk("tmo_data1", {32'd0, got[1]}, 64'h61);
    checks++;
    if (done_cyc - s_cyc < 20 || done_cyc - s_cyc > 23) begin
      errors++;
      $display("FAIL tmo_timing: done %0d cycles after start, required 20..23", done_cyc - s_cyc);
    end
    tmo_mode = 1'b0;
`else
    s_cyc = 0;
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
